// File: rtl/cnn_pkg.sv
// Shared dimensions for the binary CNN pipeline and the pixel-role
// classification used by the 2x2 max-pool stage.
package cnn_pkg;

    localparam int unsigned CONV1_OUT_W = 26;
    localparam int unsigned CONV1_OUT_H = 26;
    localparam int unsigned CONV1_CH    = 8;
    localparam int unsigned POOL1_OUT_W = CONV1_OUT_W / 2;
    localparam int unsigned POOL1_OUT_H = CONV1_OUT_H / 2;

    // What an accepted input pixel does inside its 2x2 pooling window.
    typedef enum logic [1:0] {
        PIX_HOLD     = 2'd0,  // left column: latch into the hold register
        PIX_TOP_PAIR = 2'd1,  // top-right: store top-pair OR into the line buffer
        PIX_BOT_PAIR = 2'd2,  // bottom-right: window complete, emit result
        PIX_SKIP     = 2'd3   // trailing odd row/column, never pooled
    } pix_role_e;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pool_line_buf.sv
// One pooled row of top-pair ORs: synchronous write, combinational read,
// shared address. Contents are not reset; every entry is written before use.
module pool_line_buf
    import cnn_pkg::*;
#(
    parameter int unsigned DEPTH = POOL1_OUT_W,
    parameter int unsigned CH    = CONV1_CH,
    parameter int unsigned AW    = idx_width(POOL1_OUT_W)
) (
    input  logic          clk,
    input  logic          wr_en_i,
    input  logic [AW-1:0] addr_i,
    input  logic [CH-1:0] wr_data_i,
    output logic [CH-1:0] rd_data_o
);

    logic [CH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[addr_i] <= wr_data_i;
        end
    end

    assign rd_data_o = mem_q[addr_i];

endmodule

// File: rtl/max_pool_layer_1.sv
// Binary 2x2 / stride-2 max pool (OR per window) over the conv1 raster stream,
// emitting one pooled position one cycle after each window's bottom-right pixel.
module max_pool_layer_1
    import cnn_pkg::*;
#(
    parameter int unsigned IN_W = CONV1_OUT_W,
    parameter int unsigned IN_H = CONV1_OUT_H,
    parameter int unsigned CH   = CONV1_CH
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          valid_in,
    input  logic [CH-1:0] data_in,
    output logic [CH-1:0] pool1_out,
    output logic          valid_out_pool1,
    output logic          frame_done
);

    localparam int unsigned OUT_W = IN_W / 2;
    localparam int unsigned OUT_H = IN_H / 2;
    localparam int unsigned CW    = idx_width(IN_W);
    localparam int unsigned RW    = idx_width(IN_H);
    localparam int unsigned AW    = idx_width(OUT_W);

    localparam logic [CW-1:0] COL_LAST      = CW'(IN_W - 1);
    localparam logic [RW-1:0] ROW_LAST      = RW'(IN_H - 1);
    localparam logic [CW-1:0] COL_LAST_POOL = CW'(2 * OUT_W - 1);
    localparam logic [RW-1:0] ROW_LAST_POOL = RW'(2 * OUT_H - 1);

    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    logic [CH-1:0] h_q, h_d;
    logic [CH-1:0] pool_q, pool_d;
    logic          vld_q, vld_d;
    logic          fd_q, fd_d;

    pix_role_e     role;
    logic          lb_we;
    logic [AW-1:0] lb_addr;
    logic [CH-1:0] lb_wdata;
    logic [CH-1:0] lb_rdata;

    assign lb_addr  = AW'(col_q >> 1);
    assign lb_wdata = h_q | data_in;

    // Trailing odd row/column only exists beyond the last complete window.
    always_comb begin
        role = PIX_SKIP;
        if (!col_q[0]) begin
            role = PIX_HOLD;
        end else if (col_q <= COL_LAST_POOL && row_q <= ROW_LAST_POOL) begin
            role = row_q[0] ? PIX_BOT_PAIR : PIX_TOP_PAIR;
        end
    end

    always_comb begin
        col_d  = col_q;
        row_d  = row_q;
        h_d    = h_q;
        pool_d = pool_q;
        vld_d  = 1'b0;
        fd_d   = 1'b0;
        lb_we  = 1'b0;
        if (valid_in) begin
            if (col_q == COL_LAST) begin
                col_d = '0;
                row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
            case (role)
                PIX_HOLD:     h_d = data_in;
                PIX_TOP_PAIR: lb_we = ~rst;
                PIX_BOT_PAIR: begin
                    pool_d = lb_rdata | h_q | data_in;
                    vld_d  = 1'b1;
                    fd_d   = (row_q == ROW_LAST_POOL) && (col_q == COL_LAST_POOL);
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col_q  <= '0;
            row_q  <= '0;
            h_q    <= '0;
            pool_q <= '0;
            vld_q  <= 1'b0;
            fd_q   <= 1'b0;
        end else begin
            col_q  <= col_d;
            row_q  <= row_d;
            h_q    <= h_d;
            pool_q <= pool_d;
            vld_q  <= vld_d;
            fd_q   <= fd_d;
        end
    end

    pool_line_buf #(
        .DEPTH (OUT_W),
        .CH    (CH),
        .AW    (AW)
    ) u_line_buf (
        .clk       (clk),
        .wr_en_i   (lb_we),
        .addr_i    (lb_addr),
        .wr_data_i (lb_wdata),
        .rd_data_o (lb_rdata)
    );

    assign pool1_out       = pool_q;
    assign valid_out_pool1 = vld_q;
    assign frame_done      = fd_q;

endmodule

// File: tb/tb_max_pool_layer_1.sv
// Directed bench for max_pool_layer_1: frame patterns, idle gaps, mid-frame
// reset and back-to-back frames, checked against a per-window OR of the image.
module tb_max_pool_layer_1;

    localparam int W  = 26;
    localparam int H  = 26;
    localparam int OW = 13;
    localparam int OH = 13;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       valid_in = 1'b0;
    logic [7:0] data_in = '0;
    logic [7:0] pool1_out;
    logic       valid_out_pool1;
    logic       frame_done;

    int n_asrt = 0;
    int n_fail = 0;
    int obs_n, fd_n, stray_n, out_n;
    logic [7:0] img  [0:H-1][0:W-1];
    logic [7:0] outs [0:OW*OH-1];

    max_pool_layer_1 #(.IN_W(W), .IN_H(H), .CH(8)) dut (
        .clk             (clk),
        .rst             (rst),
        .valid_in        (valid_in),
        .data_in         (data_in),
        .pool1_out       (pool1_out),
        .valid_out_pool1 (valid_out_pool1),
        .frame_done      (frame_done)
    );

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL timeout: simulation did not finish within budget");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asrt++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic sample_idle();
        if (valid_out_pool1 === 1'b1) begin
            obs_n++;
            stray_n++;
        end
        if (frame_done === 1'b1) fd_n++;
    endtask

    // mode: 0 zeros, 1 ones, 2 checkerboard, 3 single hot pixel, 4 random
    task automatic run_frame(input int mode, input int gap_max, input int npix);
        logic [7:0] exp;
        int r, c, gap;
        obs_n = 0; fd_n = 0; stray_n = 0; out_n = 0;
        for (int y = 0; y < H; y++) begin
            for (int x = 0; x < W; x++) begin
                case (mode)
                    0: img[y][x] = 8'h00;
                    1: img[y][x] = 8'hFF;
                    2: img[y][x] = (((y + x) % 2) != 0) ? 8'hFF : 8'h00;
                    3: img[y][x] = (y == 3 && x == 5) ? 8'h04 : 8'h00;
                    default: img[y][x] = 8'($urandom);
                endcase
            end
        end
        for (int p = 0; p < npix; p++) begin
            r = p / W;
            c = p % W;
            gap = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
            for (int g = 0; g < gap; g++) begin
                valid_in = 1'b0;
                @(posedge clk); #1;
                sample_idle();
            end
            valid_in = 1'b1;
            data_in  = img[r][c];
            @(posedge clk); #1;
            valid_in = 1'b0;
            if (valid_out_pool1 === 1'b1) obs_n++;
            if (frame_done === 1'b1) fd_n++;
            if ((r % 2) == 1 && (c % 2) == 1) begin
                exp = img[r-1][c-1] | img[r-1][c] | img[r][c-1] | img[r][c];
                chk($sformatf("strobe m%0d r%0d c%0d {v,fd,d}", mode, r, c),
                    {22'd0, valid_out_pool1, frame_done, pool1_out},
                    {22'd0, 1'b1, (r == H-1 && c == W-1), exp});
                if (out_n < OW*OH) outs[out_n] = pool1_out;
                out_n++;
            end else if (valid_out_pool1 !== 1'b0) begin
                stray_n++;
            end
        end
    endtask

    task automatic chk_frame_counts(input string tag);
        chk({tag, "_count"}, obs_n, OW*OH);
        chk({tag, "_fd"},    fd_n, 1);
        chk({tag, "_stray"}, stray_n, 0);
    endtask

    initial begin
        logic [7:0] acc;
        int fd_total;

        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_pool", pool1_out, 8'h00);
        chk("rst_vld",  valid_out_pool1, 1'b0);
        chk("rst_fd",   frame_done, 1'b0);
        rst = 1'b0;

        run_frame(0, 0, W*H);
        chk_frame_counts("zero");

        run_frame(1, 0, W*H);
        chk_frame_counts("ones");

        run_frame(2, 0, W*H);
        chk_frame_counts("checker");

        run_frame(3, 0, W*H);
        chk_frame_counts("hot");
        chk("hot_idx15", outs[15], 8'h04);
        acc = '0;
        for (int i = 0; i < OW*OH; i++) if (i != 15) acc |= outs[i];
        chk("hot_others", acc, 8'h00);

        run_frame(4, 3, W*H);
        chk_frame_counts("gaps");

        // 299 pixels, then the window-completing pixel 299 arrives with reset
        run_frame(4, 0, 299);
        chk("partial_count", obs_n, 5*OW + 6);
        rst = 1'b1;
        valid_in = 1'b1;
        data_in = 8'hFF;
        @(posedge clk); #1;
        rst = 1'b0;
        valid_in = 1'b0;
        chk("midrst_vld",  valid_out_pool1, 1'b0);
        chk("midrst_pool", pool1_out, 8'h00);
        chk("midrst_fd",   frame_done, 1'b0);
        @(posedge clk); #1;
        chk("midrst_idle_vld", valid_out_pool1, 1'b0);

        run_frame(4, 0, W*H);
        chk_frame_counts("after_rst");

        fd_total = 0;
        run_frame(4, 0, W*H);
        chk_frame_counts("b2b_a");
        fd_total += fd_n;
        run_frame(4, 0, W*H);
        chk_frame_counts("b2b_b");
        fd_total += fd_n;
        chk("b2b_fd_total", fd_total, 2);

        @(posedge clk); #1;
        chk("tail_vld", valid_out_pool1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule
